// File: rtl/alu_core.sv
// alu_core: registered 16-opcode ALU with one cycle of latency.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        synchronous, active-high reset; clears ALU_out and Carry_out
//   A, B       unsigned WIDTH-bit operands
//   ALU_sel    4-bit opcode; every value is defined
//   ALU_out    registered WIDTH-bit result
//   Carry_out  registered carry / borrow / overflow / divide-by-zero flag
module alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_sel,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Carry_out
);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpMul  = 4'h2;
    localparam logic [3:0] OpDiv  = 4'h3;
    localparam logic [3:0] OpShl  = 4'h4;
    localparam logic [3:0] OpShr  = 4'h5;
    localparam logic [3:0] OpRol  = 4'h6;
    localparam logic [3:0] OpRor  = 4'h7;
    localparam logic [3:0] OpAnd  = 4'h8;
    localparam logic [3:0] OpOr   = 4'h9;
    localparam logic [3:0] OpXor  = 4'hA;
    localparam logic [3:0] OpNor  = 4'hB;
    localparam logic [3:0] OpNand = 4'hC;
    localparam logic [3:0] OpXnor = 4'hD;
    localparam logic [3:0] OpGt   = 4'hE;
    localparam logic [3:0] OpEq   = 4'hF;

    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;

    // Widened intermediates so carry/borrow/overflow fall out of the top bits.
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic               b_zero;

    assign sum    = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is set exactly when A < B.
    assign diff   = {1'b0, A} - {1'b0, B};
    assign prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign b_zero = (B == '0);

    always_comb begin
        out_d   = '0;
        carry_d = 1'b0;
        unique case (ALU_sel)
            OpAdd: begin
                out_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OpSub: begin
                out_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
            end
            OpMul: begin
                out_d   = prod[WIDTH-1:0];
                carry_d = |prod[2*WIDTH-1:WIDTH];
            end
            OpDiv: begin
                // Divide-by-zero returns all ones and raises the flag.
                if (b_zero) begin
                    out_d   = '1;
                    carry_d = 1'b1;
                end else begin
                    out_d   = A / B;
                end
            end
            OpShl: begin
                out_d   = {A[WIDTH-2:0], 1'b0};
                carry_d = A[WIDTH-1];
            end
            OpShr: begin
                out_d   = {1'b0, A[WIDTH-1:1]};
                carry_d = A[0];
            end
            OpRol: begin
                out_d   = {A[WIDTH-2:0], A[WIDTH-1]};
                carry_d = A[WIDTH-1];
            end
            OpRor: begin
                out_d   = {A[0], A[WIDTH-1:1]};
                carry_d = A[0];
            end
            OpAnd:  out_d = A & B;
            OpOr:   out_d = A | B;
            OpXor:  out_d = A ^ B;
            OpNor:  out_d = ~(A | B);
            OpNand: out_d = ~(A & B);
            OpXnor: out_d = ~(A ^ B);
            OpGt:   out_d = {{(WIDTH-1){1'b0}}, (A > B)};
            OpEq:   out_d = {{(WIDTH-1){1'b0}}, (A == B)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign ALU_out   = out_q;
    assign Carry_out = carry_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed, self-checking bench for alu_core (WIDTH=8).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the
// following rising edge, so each check sees the result of the previous drive.
module tb_alu_core;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_sel;
    logic [WIDTH-1:0] ALU_out;
    logic             Carry_out;

    int checks;
    int errors;

    alu_core #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_sel  (ALU_sel),
        .ALU_out  (ALU_out),
        .Carry_out(Carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] exp_out,
                         input logic exp_c);
        checks++;
        assert (ALU_out === exp_out) else begin
            errors++;
            $error("FAIL %s: ALU_out=%h expected %h", tag, ALU_out, exp_out);
        end
        checks++;
        assert (Carry_out === exp_c) else begin
            errors++;
            $error("FAIL %s: Carry_out=%b expected %b", tag, Carry_out, exp_c);
        end
    endtask

    // Drive one operation with rst low, then wait for its edge and settle.
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [3:0] sel);
        rst     = 1'b0;
        A       = a;
        B       = b;
        ALU_sel = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        A       = 8'hFF;
        B       = 8'hFF;
        ALU_sel = 4'h2;

        // Reset held for two edges while a nonzero-producing opcode is presented.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 8'h00, 1'b0);

        // ADD
        op(8'hFF, 8'h01, 4'h0); check("add_ovf",  8'h00, 1'b1);
        op(8'h12, 8'h34, 4'h0); check("add",      8'h46, 1'b0);

        // SUB / MUL / DIV
        op(8'h05, 8'h07, 4'h1); check("sub_brw",  8'hFE, 1'b1);
        op(8'h10, 8'h10, 4'h2); check("mul_ovf",  8'h00, 1'b1);
        op(8'h0B, 8'h0B, 4'h2); check("mul",      8'h79, 1'b0);
        op(8'h64, 8'h07, 4'h3); check("div",      8'h0E, 1'b0);
        op(8'h64, 8'h00, 4'h3); check("div_zero", 8'hFF, 1'b1);

        // Shifts / rotates
        op(8'h81, 8'h00, 4'h4); check("shl",      8'h02, 1'b1);
        op(8'h81, 8'h00, 4'h5); check("shr",      8'h40, 1'b1);
        op(8'h81, 8'h00, 4'h6); check("rol",      8'h03, 1'b1);
        op(8'h81, 8'h00, 4'h7); check("ror",      8'hC0, 1'b1);
        op(8'h42, 8'h00, 4'h7); check("ror_nc",   8'h21, 1'b0);

        // Logic / compare
        op(8'hF0, 8'h3C, 4'h8); check("and",      8'h30, 1'b0);
        op(8'hF0, 8'h3C, 4'h9); check("or",       8'hFC, 1'b0);
        op(8'hF0, 8'h3C, 4'hA); check("xor",      8'hCC, 1'b0);
        op(8'hF0, 8'h3C, 4'hB); check("nor",      8'h03, 1'b0);
        op(8'hF0, 8'h3C, 4'hC); check("nand",     8'hCF, 1'b0);
        op(8'hF0, 8'h3C, 4'hD); check("xnor",     8'h33, 1'b0);
        op(8'hF0, 8'h3C, 4'hE); check("gt",       8'h01, 1'b0);
        op(8'h3C, 8'hF0, 4'hE); check("gt_false", 8'h00, 1'b0);
        op(8'hF0, 8'h3C, 4'hF); check("eq_false", 8'h00, 1'b0);
        op(8'hF0, 8'hF0, 4'hF); check("eq_true",  8'h01, 1'b0);

        // Back-to-back opcode changes on consecutive edges
        op(8'h0A, 8'h03, 4'h0); check("b2b_add",  8'h0D, 1'b0);
        op(8'h0A, 8'h03, 4'h1); check("b2b_sub",  8'h07, 1'b0);
        op(8'h0A, 8'h03, 4'h2); check("b2b_mul",  8'h1E, 1'b0);

        // Outputs hold while nothing changes
        @(posedge clk);
        #1;
        check("hold",     8'h1E, 1'b0);

        // Mid-stream reset discards the in-flight ADD
        rst     = 1'b1;
        A       = 8'hFF;
        B       = 8'h01;
        ALU_sel = 4'h0;
        @(posedge clk);
        #1;
        check("mid_rst",  8'h00, 1'b0);
        op(8'hAA, 8'hAA, 4'h8); check("post_rst", 8'hAA, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
